// File: rtl/unary_stream_gen_if.sv
// Operand handshake and unary-stream output bundle for unary_stream_gen.
// master drives the operand pair; slave is the stream generator.
interface unary_stream_gen_if #(
  parameter int unsigned W = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_val;
  logic [W-1:0] b_val;
  logic         A;
  logic         B;
  logic         en;
  logic         read_or_write;
  logic         sat;
  logic         done;

  modport master (
    output in_valid, a_val, b_val,
    input  in_ready, A, B, en, read_or_write, sat, done
  );

  modport slave (
    input  in_valid, a_val, b_val,
    output in_ready, A, B, en, read_or_write, sat, done
  );
endinterface

// File: rtl/unary_stream_gen.sv
// Converts a binary operand pair into two thermometer streams of LEN clocks,
// then holds a WR_CYC-clock adder write phase and pulses done.
module unary_stream_gen #(
  parameter int unsigned W      = 5,
  parameter int unsigned LEN    = 19,
  parameter int unsigned WR_CYC = 20
) (
  input  logic                clk,
  input  logic                rst,
  unary_stream_gen_if.slave   bus
);

  localparam logic [W-1:0] LEN_W       = W'(LEN);
  localparam logic [W-1:0] LAST_STREAM = W'(LEN - 1);
  localparam logic [W-1:0] LAST_WRITE  = W'(WR_CYC - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WRITE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] idx, idx_nxt;
  logic [W-1:0] a_lat, a_lat_nxt;
  logic [W-1:0] b_lat, b_lat_nxt;
  logic         sat_r, sat_nxt;
  logic         in_ready_r, a_r, b_r, en_r, rw_r, done_r;
  logic         in_ready_nxt, a_nxt, b_nxt, en_nxt, rw_nxt, done_nxt;

  // Next state plus the registered outputs derived from it, so the first
  // stream bit is visible in the cycle right after the transfer edge.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    a_lat_nxt = a_lat;
    b_lat_nxt = b_lat;
    sat_nxt   = sat_r;

    unique case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
          a_lat_nxt = (bus.a_val > LEN_W) ? LEN_W : bus.a_val;
          b_lat_nxt = (bus.b_val > LEN_W) ? LEN_W : bus.b_val;
          sat_nxt   = (bus.a_val > LEN_W) || (bus.b_val > LEN_W);
        end
      end
      STREAM: begin
        if (idx == LAST_STREAM) begin
          state_nxt = WRITE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + W'(1);
        end
      end
      WRITE: begin
        if (idx == LAST_WRITE) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          sat_nxt   = 1'b0;
        end else begin
          idx_nxt = idx + W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        sat_nxt   = 1'b0;
      end
    endcase

    in_ready_nxt = (state_nxt == IDLE);
    en_nxt       = (state_nxt != IDLE);
    rw_nxt       = (state_nxt == WRITE);
    a_nxt        = (state_nxt == STREAM) && (idx_nxt < a_lat_nxt);
    b_nxt        = (state_nxt == STREAM) && (idx_nxt < b_lat_nxt);
    done_nxt     = (state == WRITE) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      sat_r      <= 1'b0;
      in_ready_r <= 1'b1;
      a_r        <= 1'b0;
      b_r        <= 1'b0;
      en_r       <= 1'b0;
      rw_r       <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      a_lat      <= a_lat_nxt;
      b_lat      <= b_lat_nxt;
      sat_r      <= sat_nxt;
      in_ready_r <= in_ready_nxt;
      a_r        <= a_nxt;
      b_r        <= b_nxt;
      en_r       <= en_nxt;
      rw_r       <= rw_nxt;
      done_r     <= done_nxt;
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.A             = a_r;
  assign bus.B             = b_r;
  assign bus.en            = en_r;
  assign bus.read_or_write = rw_r;
  assign bus.sat           = sat_r;
  assign bus.done          = done_r;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Directed bench for unary_stream_gen: per-cycle output checks over whole
// frames, plus a behavioural unary adder fed by the streams.
module tb_unary_stream_gen;

  localparam int unsigned W      = 5;
  localparam int unsigned LEN    = 19;
  localparam int unsigned WR_CYC = 20;
  localparam int          PERIOD = LEN + WR_CYC + 1;

  // Output vector order: {in_ready, A, B, en, read_or_write, sat, done}
  localparam logic [6:0] IDLE_VEC = 7'b1000000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  unary_stream_gen_if #(.W(W)) bus ();

  unary_stream_gen #(.W(W), .LEN(LEN), .WR_CYC(WR_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural unary adder: counts ones in the read phase, writes out the
  // total during the write phase, clears while disabled.
  logic [7:0] acc, adder_out;
  always @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      adder_out <= '0;
    end else if (bus.en && !bus.read_or_write) begin
      acc <= acc + 8'(bus.A) + 8'(bus.B);
    end else if (bus.en && bus.read_or_write) begin
      adder_out <= acc;
    end else begin
      acc <= '0;
    end
  end

  function automatic logic [6:0] outs();
    return {bus.in_ready, bus.A, bus.B, bus.en, bus.read_or_write, bus.sat, bus.done};
  endfunction

  // Called at the negedge of frame cycle 1; walks cycles 1..PERIOD, and in the
  // done cycle presents the next operand pair (or drops in_valid).
  task automatic run_frame(input string name, input int amin, input int bmin,
                           input logic s, input logic hold, input logic nvalid,
                           input int na, input int nb);
    logic [6:0] exp;
    for (int c = 1; c <= PERIOD; c++) begin
      if (c <= int'(LEN))
        exp = {1'b0, 1'(c <= amin), 1'(c <= bmin), 1'b1, 1'b0, s, 1'b0};
      else if (c <= int'(LEN + WR_CYC))
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, s, 1'b0};
      else
        exp = 7'b1000001;
      n_cmp++;
      if (outs() !== exp) begin
        n_bad++;
        $display("FAIL %s cycle %0d: outputs got %b expected %b", name, c, outs(), exp);
      end
      if (c == PERIOD) begin
        n_cmp++;
        if (adder_out !== 8'(amin + bmin)) begin
          n_bad++;
          $display("FAIL %s adder_count: got %0d expected %0d", name, adder_out, amin + bmin);
        end
        bus.in_valid = nvalid;
        bus.a_val    = W'(na);
        bus.b_val    = W'(nb);
      end else begin
        bus.in_valid = hold;
        bus.a_val    = W'($urandom_range(0, 31));
        bus.b_val    = W'($urandom_range(0, 31));
      end
      @(negedge clk);
    end
  endtask

  task automatic start(input int a, input int b);
    bus.in_valid = 1'b1;
    bus.a_val    = W'(a);
    bus.b_val    = W'(b);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_val    = W'(3);
    bus.b_val    = W'(5);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected %b", outs(), IDLE_VEC);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL reset_priority: got %b expected %b", outs(), IDLE_VEC);
    end
  endtask

  task automatic test_basic();
    start(3, 5);
    run_frame("basic_3_5", 3, 5, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_zero_full();
    start(0, 19);
    run_frame("zero_full", 0, 19, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_saturate();
    start(25, 2);
    run_frame("saturate", 19, 2, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    start(7, 11);
    run_frame("b2b_0", 7, 11, 1'b0, 1'b1, 1'b1, 31, 0);
    run_frame("b2b_1", 19, 0, 1'b1, 1'b1, 1'b1, 19, 19);
    run_frame("b2b_2", 19, 19, 1'b0, 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL b2b_idle_after: got %b expected %b", outs(), IDLE_VEC);
    end
  endtask

  task automatic test_reset_mid_stream();
    start(10, 4);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (outs() !== IDLE_VEC) begin
        n_bad++;
        $display("FAIL mid_reset_idle %0d: got %b expected %b", k, outs(), IDLE_VEC);
      end
      @(negedge clk);
    end
    start(12, 6);
    run_frame("after_reset", 12, 6, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a_val    = '0;
    bus.b_val    = '0;
    rst          = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_full();
    test_saturate();
    test_back_to_back();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
